div_unit: RTL and testbench

Multi-cycle 32-bit integer divider with its own sequencing state machine, sitting beside the execute stage of the five-stage MIPS pipeline. The execute stage hands it a DIV/DIVU operand pair and holds `start_i` high; the unit runs a radix-2 restoring division over 32 iterations and reports `{remainder, quotient}`. The execute stage stalls the pipeline while `busy_o` is high.

---
 rtl/div_unit_pkg.sv | 22 ++
 rtl/div_unit_step.sv | 20 ++
 rtl/div_unit.sv | 136 +++++++++++++
 tb/tb_div_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared divider definitions: FSM state encodings, ready/start levels, sign helper.
package div_unit_pkg;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;

   localparam logic [5:0] DIV_ITERATIONS = 6'd32;

   function automatic logic [31:0] twos_neg(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift in next dividend bit, trial-subtract divisor.
// Combinational; no backpressure.
module div_step (
   input  logic [31:0] rem_i,
   input  logic [31:0] quo_i,
   input  logic [31:0] divisor_i,
   output logic [31:0] rem_o,
   output logic [31:0] quo_o
);
   logic [32:0] shifted;
   logic [32:0] diff;
   logic        fits;

   assign shifted = {rem_i, quo_i[31]};
   assign diff    = shifted - {1'b0, divisor_i};
   // Remainder is always below the divisor, so a set shifted[32] can never underflow.
   assign fits    = shifted[32] | ~diff[32];
   assign rem_o   = fits ? diff[31:0] : shifted[31:0];
   assign quo_o   = {quo_i[30:0], fits};
endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit divider: 34 edges start-to-ready (2 on divide-by-zero); result held while start_i stays high.
// Signed DIV support (magnitudes and sign fix) is present only when DIV_SIGNED_EN is defined.
module div_unit
   import div_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o,
   output logic        busy_o
);
   div_state_e  state_q;
   logic [5:0]  cnt_q;
   logic [31:0] rem_q, quo_q, divisor_q;
   logic [63:0] result_q;
   logic        ready_q, busy_q;

   logic [31:0] dividend_mag, divisor_mag;
   logic [31:0] rem_fix, quo_fix;
   logic [31:0] rem_d, quo_d;
   logic        accept;

   assign accept = (start_i == DIV_START) && !annul_i;

`ifdef DIV_SIGNED_EN
   logic dvd_neg_q, dvs_neg_q;

   assign dividend_mag = (signed_div_i && opdata1_i[31]) ? twos_neg(opdata1_i) : opdata1_i;
   assign divisor_mag  = (signed_div_i && opdata2_i[31]) ? twos_neg(opdata2_i) : opdata2_i;
   assign quo_fix      = (dvd_neg_q ^ dvs_neg_q) ? twos_neg(quo_q) : quo_q;
   assign rem_fix      = dvd_neg_q ? twos_neg(rem_q) : rem_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_neg_q <= 1'b0;
         dvs_neg_q <= 1'b0;
      end else if (state_q == DIV_FREE && accept) begin
         dvd_neg_q <= signed_div_i & opdata1_i[31];
         dvs_neg_q <= signed_div_i & opdata2_i[31];
      end
   end
`else
   logic unused_signed;

   assign unused_signed = signed_div_i;
   assign dividend_mag  = opdata1_i;
   assign divisor_mag   = opdata2_i;
   assign quo_fix       = quo_q;
   assign rem_fix       = rem_q;
`endif

   div_step u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (divisor_q),
      .rem_o     (rem_d),
      .quo_o     (quo_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= DIV_FREE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         divisor_q <= '0;
         result_q  <= '0;
         ready_q   <= DIV_RESULT_NOT_READY;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            DIV_FREE: begin
               if (accept) begin
                  busy_q <= 1'b1;
                  if (opdata2_i == 32'd0) begin
                     state_q <= DIV_BYZERO;
                  end else begin
                     state_q   <= DIV_ON;
                     cnt_q     <= '0;
                     rem_q     <= '0;
                     quo_q     <= dividend_mag;
                     divisor_q <= divisor_mag;
                  end
               end
            end
            DIV_BYZERO: begin
               busy_q <= 1'b0;
               if (annul_i) begin
                  state_q <= DIV_FREE;
               end else begin
                  state_q  <= DIV_END;
                  result_q <= '0;
                  ready_q  <= DIV_RESULT_READY;
               end
            end
            DIV_ON: begin
               if (annul_i) begin
                  state_q <= DIV_FREE;
                  busy_q  <= 1'b0;
               end else if (cnt_q != DIV_ITERATIONS) begin
                  rem_q <= rem_d;
                  quo_q <= quo_d;
                  cnt_q <= cnt_q + 6'd1;
               end else begin
                  state_q  <= DIV_END;
                  result_q <= {rem_fix, quo_fix};
                  ready_q  <= DIV_RESULT_READY;
                  busy_q   <= 1'b0;
               end
            end
            DIV_END: begin
               if (start_i == DIV_STOP) begin
                  state_q  <= DIV_FREE;
                  result_q <= '0;
                  ready_q  <= DIV_RESULT_NOT_READY;
               end
            end
            default: begin
               state_q  <= DIV_FREE;
               result_q <= '0;
               ready_q  <= DIV_RESULT_NOT_READY;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;
   assign busy_o   = busy_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; signed expectations follow the DIV_SIGNED_EN build.
module tb_div_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        busy_o;

   int compared   = 0;
   int mismatched = 0;

   div_unit dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   // Starts an operation and waits (bounded) for ready_o; edges counts clock edges after the accepting edge.
   task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int edges, output logic bad_flags);
      int k;
      signed_div_i = sd;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      bad_flags    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      k = 0;
      while (!ready_o && k < 40) begin
         if (!busy_o) bad_flags = 1'b1;
         @(posedge clk);
         k++;
         @(negedge clk);
         if (ready_o && busy_o) bad_flags = 1'b1;
      end
      edges = k;
      res   = result_o;
   endtask

   task automatic release_start();
      start_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
      start_i = 1'b0; annul_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      compared++;
      if ({result_o, ready_o, busy_o} !== 66'd0) begin
         mismatched++;
         $display("FAIL reset_outputs: got res=%h rdy=%b busy=%b, want all 0", result_o, ready_o, busy_o);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_unsigned();
      logic [63:0] res; int edges; logic bad; logic [63:0] held;
      do_div(1'b0, 32'd100, 32'd7, res, edges, bad);
      compared++;
      if (edges !== 33) begin
         mismatched++; $display("FAIL u100_7_latency: got %0d edges after start, want 33", edges);
      end
      compared++;
      if (res !== 64'h00000002_0000000E) begin
         mismatched++; $display("FAIL u100_7_result: got %h want 000000020000000e", res);
      end
      compared++;
      if (bad !== 1'b0) begin
         mismatched++; $display("FAIL u100_7_busy: busy gap or busy&ready overlap seen, got %b want 0", bad);
      end
      held = result_o;
      @(posedge clk);
      @(negedge clk);
      compared++;
      if (ready_o !== 1'b1 || result_o !== 64'h00000002_0000000E) begin
         mismatched++; $display("FAIL u100_7_hold: got rdy=%b res=%h want rdy=1 res=%h", ready_o, result_o, held);
      end
      release_start();
      compared++;
      if (ready_o !== 1'b0 || result_o !== 64'd0) begin
         mismatched++; $display("FAIL u100_7_drop: got rdy=%b res=%h want 0/0", ready_o, result_o);
      end
   endtask

   task automatic test_unsigned_max();
      logic [63:0] res; int edges; logic bad;
      do_div(1'b0, 32'hFFFFFFFF, 32'h10, res, edges, bad);
      compared++;
      if (res !== 64'h0000000F_0FFFFFFF) begin
         mismatched++; $display("FAIL umax_16: got %h want 0000000f0fffffff", res);
      end
      release_start();
   endtask

   task automatic test_signed();
      logic [63:0] res; int edges; logic bad; logic [63:0] exp;
`ifdef DIV_SIGNED_EN
      exp = 64'hFFFFFFFF_FFFFFFFD;
`else
      exp = 64'h00000001_7FFFFFFC;
`endif
      do_div(1'b1, 32'hFFFFFFF9, 32'd2, res, edges, bad);
      compared++;
      if (res !== exp) begin
         mismatched++; $display("FAIL sneg7_2: got %h want %h", res, exp);
      end
      release_start();
`ifdef DIV_SIGNED_EN
      exp = 64'h00000002_FFFFFFF2;
`else
      exp = 64'h00000064_00000000;
`endif
      do_div(1'b1, 32'd100, 32'hFFFFFFF9, res, edges, bad);
      compared++;
      if (res !== exp) begin
         mismatched++; $display("FAIL s100_neg7: got %h want %h", res, exp);
      end
      release_start();
   endtask

   task automatic test_min_neg1();
      logic [63:0] res; int edges; logic bad; logic [63:0] exp;
`ifdef DIV_SIGNED_EN
      exp = 64'h00000000_80000000;
`else
      exp = 64'h80000000_00000000;
`endif
      do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, res, edges, bad);
      compared++;
      if (edges !== 33 || res !== exp) begin
         mismatched++; $display("FAIL min_neg1: got edges=%0d res=%h want 33 / %h", edges, res, exp);
      end
      release_start();
   endtask

   task automatic test_byzero();
      logic [63:0] res; int edges; logic bad;
      do_div(1'b0, 32'd55, 32'd0, res, edges, bad);
      compared++;
      if (edges !== 1 || bad !== 1'b0) begin
         mismatched++; $display("FAIL byzero_timing: got edges=%0d flags=%b want 1 / 0", edges, bad);
      end
      compared++;
      if (res !== 64'd0 || ready_o !== 1'b1) begin
         mismatched++; $display("FAIL byzero_result: got res=%h rdy=%b want 0 / 1", res, ready_o);
      end
      release_start();
   endtask

   task automatic test_annul();
      logic [63:0] res; int edges; logic bad; logic seen;
      signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      compared++;
      if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
         mismatched++; $display("FAIL annul_idle: got busy=%b rdy=%b want 0/0", busy_o, ready_o);
      end
      annul_i = 1'b0; start_i = 1'b0;
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (ready_o || busy_o) seen = 1'b1;
      end
      compared++;
      if (seen !== 1'b0) begin
         mismatched++; $display("FAIL annul_no_result: got ready/busy activity=%b want 0", seen);
      end
      do_div(1'b0, 32'd9, 32'd3, res, edges, bad);
      compared++;
      if (res !== 64'h00000000_00000003 || edges !== 33) begin
         mismatched++; $display("FAIL after_annul_9_3: got res=%h edges=%0d want 3 / 33", res, edges);
      end
      release_start();
   endtask

   task automatic test_back_to_back();
      logic [63:0] res; int edges; logic bad;
      do_div(1'b0, 32'd1000, 32'd10, res, edges, bad);
      compared++;
      if (res !== 64'h00000000_00000064) begin
         mismatched++; $display("FAIL b2b_first: got %h want 0000000000000064", res);
      end
      release_start();
      do_div(1'b0, 32'd12345, 32'd100, res, edges, bad);
      compared++;
      if (res !== 64'h0000002D_0000007B || edges !== 33) begin
         mismatched++; $display("FAIL b2b_second: got res=%h edges=%0d want 0000002d0000007b / 33", res, edges);
      end
      release_start();
   endtask

   task automatic test_reset_mid();
      signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
      @(posedge clk);
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst = 1'b1; start_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      compared++;
      if ({result_o, ready_o, busy_o} !== 66'd0) begin
         mismatched++; $display("FAIL reset_mid: got res=%h rdy=%b busy=%b want all 0", result_o, ready_o, busy_o);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      compared++;
      if (ready_o !== 1'b0 || busy_o !== 1'b0) begin
         mismatched++; $display("FAIL reset_mid_quiet: got rdy=%b busy=%b want 0/0", ready_o, busy_o);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_unsigned_max();
      test_signed();
      test_min_neg1();
      test_byzero();
      test_annul();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
